// File: rtl/ro_freq_controller.sv
// Ring-oscillator frequency loop: counts RO edges per clk window and steps a saturating current-source code.
// Optional macro RO_FREQ_MINMAX_EN adds cnt_min/cnt_max tracking since the last loop start.
module ro_freq_controller #(
    parameter int WIN_W      = 10,
    parameter int CNT_W      = 12,
    parameter int CODE_W     = 6,
    parameter int DEADBAND   = 2,
    parameter int WARMUP_CYC = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic [WIN_W-1:0]  win_len,
    input  logic [CNT_W-1:0]  target,
    input  logic              osc_in,
    output logic              ro_start,
    output logic [CODE_W-1:0] code,
    output logic [CNT_W-1:0]  count_out,
    output logic              count_valid,
    output logic              locked
`ifdef RO_FREQ_MINMAX_EN
   ,output logic [CNT_W-1:0]  cnt_min,
    output logic [CNT_W-1:0]  cnt_max
`endif
);

    localparam int WARM_W = (WARMUP_CYC > 1) ? $clog2(WARMUP_CYC) : 1;
    localparam logic [CODE_W-1:0] CODE_MID = CODE_W'(1 << (CODE_W - 1));
    localparam logic [CODE_W-1:0] CODE_MAX = '1;
    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
    localparam logic [WARM_W-1:0] WARM_LOAD = WARM_W'(WARMUP_CYC - 1);
    localparam logic [CNT_W:0]    DB_EXT   = (CNT_W + 1)'(DEADBAND);

    typedef enum logic [1:0] {
        IDLE,
        WARMUP,
        MEASURE,
        UPDATE
    } state_t;

    state_t             state;
    logic [WARM_W-1:0]  warm_cnt;
    logic [WIN_W-1:0]   win_cnt;
    logic [CNT_W-1:0]   edge_cnt;
    logic               inband_prev;

    logic osc_s1, osc_s2, osc_s3;
    logic osc_rise;

    // Two-flop synchronizer plus one history flop for rising-edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            osc_s1 <= 1'b0;
            osc_s2 <= 1'b0;
            osc_s3 <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments let the three flops shift in one edge without ordering races.
            osc_s1 <= osc_in;
            osc_s2 <= osc_s1;
            osc_s3 <= osc_s2;
        end
    end

    assign osc_rise = osc_s2 & ~osc_s3;

    logic [WIN_W-1:0] win_eff;
    logic [CNT_W:0]   cnt_ext;
    logic [CNT_W:0]   tgt_ext;
    logic             too_low;
    logic             too_high;

    // One extra bit keeps target + DEADBAND from wrapping.
    assign win_eff  = (win_len == '0) ? WIN_W'(1) : win_len;
    assign cnt_ext  = {1'b0, edge_cnt};
    assign tgt_ext  = {1'b0, target};
    assign too_low  = (cnt_ext + DB_EXT) < tgt_ext;
    assign too_high = cnt_ext > (tgt_ext + DB_EXT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            warm_cnt    <= '0;
            win_cnt     <= '0;
            edge_cnt    <= '0;
            inband_prev <= 1'b0;
            ro_start    <= 1'b0;
            code        <= CODE_MID;
            count_out   <= '0;
            count_valid <= 1'b0;
            locked      <= 1'b0;
`ifdef RO_FREQ_MINMAX_EN
            cnt_min     <= '1;
            cnt_max     <= '0;
`endif
        end else begin
            count_valid <= 1'b0;
            case (state)
                IDLE: begin
                    ro_start    <= 1'b0;
                    locked      <= 1'b0;
                    inband_prev <= 1'b0;
                    if (enable) begin
                        state    <= WARMUP;
                        ro_start <= 1'b1;
                        warm_cnt <= WARM_LOAD;
`ifdef RO_FREQ_MINMAX_EN
                        cnt_min  <= '1;
                        cnt_max  <= '0;
`endif
                    end
                end

                WARMUP: begin
                    if (!enable) begin
                        state       <= IDLE;
                        ro_start    <= 1'b0;
                        locked      <= 1'b0;
                        inband_prev <= 1'b0;
                    end else if (warm_cnt == '0) begin
                        state    <= MEASURE;
                        win_cnt  <= win_eff;
                        edge_cnt <= '0;
                    end else begin
                        warm_cnt <= warm_cnt - WARM_W'(1);
                    end
                end

                MEASURE: begin
                    if (!enable) begin
                        // Partial window is dropped; no count_valid.
                        state       <= IDLE;
                        ro_start    <= 1'b0;
                        locked      <= 1'b0;
                        inband_prev <= 1'b0;
                    end else begin
                        if (osc_rise && edge_cnt != CNT_MAX)
                            edge_cnt <= edge_cnt + CNT_W'(1);
                        if (win_cnt <= WIN_W'(1))
                            state <= UPDATE;
                        else
                            win_cnt <= win_cnt - WIN_W'(1);
                    end
                end

                UPDATE: begin
                    count_out   <= edge_cnt;
                    count_valid <= 1'b1;
`ifdef RO_FREQ_MINMAX_EN
                    if (edge_cnt < cnt_min) cnt_min <= edge_cnt;
                    if (edge_cnt > cnt_max) cnt_max <= edge_cnt;
`endif
                    if (too_low) begin
                        if (code != CODE_MAX) code <= code + CODE_W'(1);
                        locked      <= 1'b0;
                        inband_prev <= 1'b0;
                    end else if (too_high) begin
                        if (code != '0) code <= code - CODE_W'(1);
                        locked      <= 1'b0;
                        inband_prev <= 1'b0;
                    end else begin
                        if (inband_prev) locked <= 1'b1;
                        inband_prev <= 1'b1;
                    end

                    if (enable) begin
                        state    <= MEASURE;
                        win_cnt  <= win_eff;
                        edge_cnt <= '0;
                    end else begin
                        // Later assignments override the lock decision above.
                        state       <= IDLE;
                        ro_start    <= 1'b0;
                        locked      <= 1'b0;
                        inband_prev <= 1'b0;
                    end
                end

                default: begin
                    state    <= IDLE;
                    ro_start <= 1'b0;
                end
            endcase
        end
    end

endmodule
